// File: rtl/gradient_context_scheduler_if.sv
// Pixel-in / context-out streaming bundle for the gradient context scheduler.
// Both streams transfer on a rising edge where valid && ready; the source keeps data stable while valid is high and ready is low.
interface gradient_context_scheduler_if #(
    parameter int pixel_length      = 8,
    parameter int quantizedQ_length = 4
);
    logic                         frame_start;
    logic [pixel_length-1:0]      pixel_in;
    logic                         pixel_valid;
    logic                         pixel_ready;
    logic [quantizedQ_length-1:0] D_1;
    logic [quantizedQ_length-1:0] D_2;
    logic [quantizedQ_length-1:0] D_3;
    logic                         sign;
    logic [8:0]                   context_idx;
    logic                         run_mode;
    logic [pixel_length-1:0]      pixel_out;
    logic                         out_valid;
    logic                         out_ready;
    logic                         busy;
    logic                         frame_done;
    logic [1:0]                   fsm_state;

    modport slave (
        input  frame_start, pixel_in, pixel_valid, out_ready,
        output pixel_ready, D_1, D_2, D_3, sign, context_idx, run_mode,
               pixel_out, out_valid, busy, frame_done, fsm_state
    );

    modport master (
        output frame_start, pixel_in, pixel_valid, out_ready,
        input  pixel_ready, D_1, D_2, D_3, sign, context_idx, run_mode,
               pixel_out, out_valid, busy, frame_done, fsm_state
    );
endinterface

// File: rtl/gradient_context_scheduler.sv
// Raster-order scheduler: builds JPEG-LS neighbours a/b/c/d from a one-row buffer and
// emits quantized gradients plus merged context through a 2-stage valid/ready pipeline.
module gradient_context_scheduler #(
    parameter int pixel_length      = 8,
    parameter int quantizedQ_length = 4,
    parameter int IMAGE_WIDTH       = 64,
    parameter int IMAGE_HEIGHT      = 64
) (
    input logic                          clk,
    input logic                          reset_n,
    gradient_context_scheduler_if.slave  bus
);
    localparam int PL = pixel_length;
    localparam int QW = quantizedQ_length;
    localparam int GW = PL + 1;
    localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t         state, state_nx;
    logic [RW-1:0]  row;
    logic [CW-1:0]  col;
    logic [CW-1:0]  col_inc;
    logic           col_last;
    logic           last_px;
    logic [PL-1:0]  rowbuf [IMAGE_WIDTH];
    logic [PL-1:0]  prev_x, prev_b, col0_a;
    logic [PL-1:0]  a_n, b_n, c_n, d_n;

    logic           s1_valid;
    logic [PL-1:0]  s1_a, s1_b, s1_c, s1_d, s1_x;
    logic           s2_valid;
    logic [QW-1:0]  s2_d1, s2_d2, s2_d3;
    logic           s2_sign, s2_run;
    logic [8:0]     s2_ctx;
    logic [PL-1:0]  s2_x;

    logic           s2_free, pixel_ready, accept;
    logic [GW-1:0]  g1, g2, g3;
    logic [QW-1:0]  q1, q2, q3, m1, m2, m3;
    logic [8:0]     e1, e2, e3, ctx;
    logic           neg, run;

    function automatic logic [QW-1:0] quantize(input logic [GW-1:0] g);
        logic [GW-1:0] mag;
        logic [QW-1:0] m;
        mag = g[GW-1] ? (~g + 1'b1) : g;
        if (mag == '0)           m = QW'(0);
        else if (mag < GW'(3))   m = QW'(1);
        else if (mag < GW'(7))   m = QW'(2);
        else if (mag < GW'(21))  m = QW'(3);
        else                     m = QW'(4);
        return g[GW-1] ? (~m + 1'b1) : m;
    endfunction

    assign s2_free     = !s2_valid || bus.out_ready;
    assign pixel_ready = (state == ACTIVE) && (!s1_valid || s2_free);
    assign accept      = bus.pixel_valid && pixel_ready;
    assign col_last    = (col == CW'(IMAGE_WIDTH - 1));
    assign col_inc     = col + 1'b1;
    assign last_px     = col_last && (row == RW'(IMAGE_HEIGHT - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.frame_start) state_nx = ACTIVE;
            ACTIVE:  if (accept && last_px) state_nx = DRAIN;
            DRAIN:   if (!s1_valid && !s2_valid) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Row 0 has no upper neighbours; column 0 borrows its a from above and its c from the row before.
    always_comb begin
        a_n = '0;
        b_n = '0;
        c_n = '0;
        d_n = '0;
        if (row == '0) begin
            a_n = (col == '0) ? '0 : prev_x;
        end else begin
            b_n = rowbuf[col];
            d_n = col_last ? rowbuf[col] : rowbuf[col_inc];
            if (col == '0) begin
                a_n = rowbuf[col];
                c_n = col0_a;
            end else begin
                a_n = prev_x;
                c_n = prev_b;
            end
        end
    end

    always_comb begin
        g1  = {1'b0, s1_d} - {1'b0, s1_b};
        g2  = {1'b0, s1_b} - {1'b0, s1_c};
        g3  = {1'b0, s1_c} - {1'b0, s1_a};
        q1  = quantize(g1);
        q2  = quantize(g2);
        q3  = quantize(g3);
        neg = 1'b0;
        if (q1 != '0)      neg = q1[QW-1];
        else if (q2 != '0) neg = q2[QW-1];
        else               neg = q3[QW-1];
        m1  = neg ? (~q1 + 1'b1) : q1;
        m2  = neg ? (~q2 + 1'b1) : q2;
        m3  = neg ? (~q3 + 1'b1) : q3;
        e1  = {{(9-QW){m1[QW-1]}}, m1};
        e2  = {{(9-QW){m2[QW-1]}}, m2};
        e3  = {{(9-QW){m3[QW-1]}}, m3};
        // The merged index is always 0..364, so modulo-512 arithmetic gives the exact value.
        ctx = 9'd81 * e1 + 9'd9 * e2 + e3;
        run = (q1 == '0) && (q2 == '0) && (q3 == '0);
        if (run) begin
            ctx = '0;
            neg = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) rowbuf[col] <= bus.pixel_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            prev_x   <= '0;
            prev_b   <= '0;
            col0_a   <= '0;
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
            s1_d     <= '0;
            s1_x     <= '0;
            s2_valid <= 1'b0;
            s2_d1    <= '0;
            s2_d2    <= '0;
            s2_d3    <= '0;
            s2_sign  <= 1'b0;
            s2_ctx   <= '0;
            s2_run   <= 1'b0;
            s2_x     <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.frame_start) begin
                row    <= '0;
                col    <= '0;
                prev_x <= '0;
                prev_b <= '0;
                col0_a <= '0;
            end
            if (accept) begin
                prev_x <= bus.pixel_in;
                prev_b <= b_n;
                if (col == '0) col0_a <= a_n;
                if (col_last) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col_inc;
                end
            end
            if (!s1_valid || s2_free) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_a <= a_n;
                    s1_b <= b_n;
                    s1_c <= c_n;
                    s1_d <= d_n;
                    s1_x <= bus.pixel_in;
                end
            end
            if (s2_free) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_d1   <= q1;
                    s2_d2   <= q2;
                    s2_d3   <= q3;
                    s2_sign <= neg;
                    s2_ctx  <= ctx;
                    s2_run  <= run;
                    s2_x    <= s1_x;
                end
            end
        end
    end

    assign bus.pixel_ready = pixel_ready;
    assign bus.D_1         = s2_d1;
    assign bus.D_2         = s2_d2;
    assign bus.D_3         = s2_d3;
    assign bus.sign        = s2_sign;
    assign bus.context_idx = s2_ctx;
    assign bus.run_mode    = s2_run;
    assign bus.pixel_out   = s2_x;
    assign bus.out_valid   = s2_valid;
    assign bus.busy        = (state != IDLE);
    assign bus.frame_done  = (state == DONE);
    assign bus.fsm_state   = state;
endmodule

// File: tb/tb_gradient_context_scheduler.sv
// Directed bench for gradient_context_scheduler on a 4x4 frame: hand-computed contexts,
// a JPEG-LS reference model for whole frames, backpressure, and reset mid-frame.
module tb_gradient_context_scheduler;
    localparam int PL = 8;
    localparam int QW = 4;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int N  = W * H;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    gradient_context_scheduler_if #(.pixel_length(PL), .quantizedQ_length(QW)) bus ();

    gradient_context_scheduler #(
        .pixel_length(PL), .quantizedQ_length(QW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int first_acc, first_ov, fd_cnt;
    logic [30:0] exp_q[$];
    logic [30:0] cap_q[$];
    logic [7:0]  frame_px [N];

    // Bundle layout: pixel[30:23] D_1[22:19] D_2[18:15] D_3[14:11] sign[10] ctx[9:1] run[0]
    function automatic logic [30:0] pack_out();
        return {bus.pixel_out, bus.D_1, bus.D_2, bus.D_3, bus.sign, bus.context_idx, bus.run_mode};
    endfunction

    always @(negedge clk) begin
        if (reset_n && bus.out_valid && bus.out_ready) cap_q.push_back(pack_out());
    end

    function automatic int qnt(input int g);
        int m;
        m = (g < 0) ? -g : g;
        if (m == 0)       m = 0;
        else if (m <= 2)  m = 1;
        else if (m <= 6)  m = 2;
        else if (m <= 20) m = 3;
        else              m = 4;
        return (g < 0) ? -m : m;
    endfunction

    task automatic build_exp();
        int a, b, c, d, q1, q2, q3, ctx;
        logic neg, run;
        exp_q.delete();
        for (int r = 0; r < H; r++) begin
            for (int k = 0; k < W; k++) begin
                if (r == 0) begin
                    b = 0; c = 0; d = 0;
                    a = (k == 0) ? 0 : int'(frame_px[k-1]);
                end else begin
                    b = frame_px[(r-1)*W + k];
                    d = (k == W-1) ? b : int'(frame_px[(r-1)*W + k + 1]);
                    if (k == 0) begin
                        a = b;
                        c = (r == 1) ? 0 : int'(frame_px[(r-2)*W]);
                    end else begin
                        a = frame_px[r*W + k - 1];
                        c = frame_px[(r-1)*W + k - 1];
                    end
                end
                q1 = qnt(d - b);
                q2 = qnt(b - c);
                q3 = qnt(c - a);
                neg = (q1 != 0) ? (q1 < 0) : (q2 != 0) ? (q2 < 0) : (q3 < 0);
                ctx = neg ? -(81*q1 + 9*q2 + q3) : (81*q1 + 9*q2 + q3);
                run = (q1 == 0) && (q2 == 0) && (q3 == 0);
                exp_q.push_back({frame_px[r*W+k], 4'(q1), 4'(q2), 4'(q3), neg, 9'(ctx), run});
            end
        end
    endtask

    task automatic run_frame(input int stall_at, input int stall_len, input int fs_at);
        int idx, cyc;
        logic acc;
        logic [30:0] held;
        idx = 0; cyc = 0; held = '0;
        cap_q.delete(); fd_cnt = 0; first_acc = -1; first_ov = -1;
        bus.out_ready = 1'b1;
        bus.frame_start = 1'b1;
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
        while (idx < N && cyc < 200) begin
            bus.pixel_valid = 1'b1;
            bus.pixel_in    = frame_px[idx];
            bus.out_ready   = !(cyc >= stall_at && cyc < stall_at + stall_len);
            bus.frame_start = (cyc == fs_at);
            @(negedge clk);
            acc = bus.pixel_ready;
            if (acc && first_acc < 0) first_acc = cyc;
            if (bus.out_valid && first_ov < 0) first_ov = cyc;
            if (cyc == stall_at) held = pack_out();
            if (cyc > stall_at && cyc < stall_at + stall_len) begin
                total++;
                if ({bus.out_valid, pack_out()} !== {1'b1, held}) begin
                    bad++;
                    $display("FAIL stall_hold cyc=%0d: got %h expected %h", cyc, {bus.out_valid, pack_out()}, {1'b1, held});
                end
            end
            if (stall_len > 0 && cyc == stall_at + stall_len - 1) begin
                total++;
                if (bus.pixel_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_pixel_ready: got %b expected 0", bus.pixel_ready);
                end
            end
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        total++;
        if (idx != N) begin
            bad++;
            $display("FAIL pixel_budget: got %0d accepted expected %0d", idx, N);
        end
        bus.pixel_valid = 1'b0;
        bus.frame_start = 1'b0;
        bus.out_ready   = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (bus.frame_done) fd_cnt++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.frame_start = 1'b0; bus.pixel_in = '0; bus.pixel_valid = 1'b0; bus.out_ready = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.out_valid, bus.busy, bus.frame_done, bus.pixel_ready, bus.fsm_state} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b expected 000000", {bus.out_valid, bus.busy, bus.frame_done, bus.pixel_ready, bus.fsm_state});
        end
        total++;
        if (pack_out() !== 31'h0) begin
            bad++;
            $display("FAIL reset_data: got %h expected 0", pack_out());
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({bus.busy, bus.pixel_ready} !== 2'b00) begin
            bad++;
            $display("FAIL idle_after_reset: got %b expected 00", {bus.busy, bus.pixel_ready});
        end
    endtask

    task automatic test_positive_context();
        logic [30:0] bnd;
        frame_px = '{15, 20, 40, 50, 10, 60, 70, 80, 90, 100, 110, 120, 130, 140, 150, 160};
        build_exp();
        run_frame(-1, 0, -1);
        total++;
        if (first_ov - first_acc != 2) begin
            bad++;
            $display("FAIL latency: got %0d expected 2", first_ov - first_acc);
        end
        total++;
        if (cap_q.size() != N) begin
            bad++;
            $display("FAIL pos_count: got %0d expected %0d", cap_q.size(), N);
        end
        bnd = (cap_q.size() > 5) ? cap_q[5] : '0;
        total++;
        if (bnd !== {8'd60, 4'd3, 4'd2, 4'd2, 1'b0, 9'd263, 1'b0}) begin
            bad++;
            $display("FAIL pos_ctx: got %h expected %h", bnd, {8'd60, 4'd3, 4'd2, 4'd2, 1'b0, 9'd263, 1'b0});
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL pos_model[%0d]: got %h expected %h", i, (i < cap_q.size()) ? cap_q[i] : 'x, exp_q[i]);
            end
        end
    endtask

    task automatic test_negative_context();
        logic [30:0] bnd;
        frame_px = '{15, 10, 0, 3, 20, 200, 7, 7, 30, 31, 90, 12, 0, 255, 128, 64};
        run_frame(-1, 0, -1);
        bnd = (cap_q.size() > 5) ? cap_q[5] : '0;
        total++;
        if (bnd[22:0] !== {4'd13, 4'd14, 4'd14, 1'b1, 9'd263, 1'b0}) begin
            bad++;
            $display("FAIL neg_ctx: got %h expected %h", bnd[22:0], {4'd13, 4'd14, 4'd14, 1'b1, 9'd263, 1'b0});
        end
    endtask

    task automatic test_flat();
        logic [30:0] bnd;
        for (int i = 0; i < N; i++) frame_px[i] = 8'd100;
        run_frame(-1, 0, -1);
        total++;
        if (cap_q.size() != N || fd_cnt != 1) begin
            bad++;
            $display("FAIL flat_count: got %0d bundles %0d done expected %0d bundles 1 done", cap_q.size(), fd_cnt, N);
        end
        // Row 0 (after col 0) and the col-0 sample of row 1 see zero-valued neighbours, so only the interior is flat.
        for (int i = 0; i < N; i++) begin
            if (i == 0 || i >= W + 1) begin
                bnd = (i < cap_q.size()) ? cap_q[i] : '1;
                total++;
                if ({bnd[9:1], bnd[0]} !== {9'd0, 1'b1}) begin
                    bad++;
                    $display("FAIL flat_run[%0d]: got ctx=%0d run=%b expected ctx=0 run=1", i, bnd[9:1], bnd[0]);
                end
            end
        end
        total++;
        if ({bus.busy, bus.fsm_state} !== 3'b000) begin
            bad++;
            $display("FAIL flat_idle: got %b expected 000", {bus.busy, bus.fsm_state});
        end
    endtask

    task automatic test_row0_edges();
        logic [30:0] bnd;
        for (int i = 0; i < N; i++) frame_px[i] = 8'(5 + 4*i);
        run_frame(-1, 0, -1);
        bnd = (cap_q.size() > 1) ? cap_q[1] : '0;
        total++;
        if (bnd[22:0] !== {4'd0, 4'd0, 4'd14, 1'b1, 9'd2, 1'b0}) begin
            bad++;
            $display("FAIL row0_col1: got %h expected %h", bnd[22:0], {4'd0, 4'd0, 4'd14, 1'b1, 9'd2, 1'b0});
        end
        bnd = (cap_q.size() > 4) ? cap_q[4] : '0;
        total++;
        if (bnd[22:0] !== {4'd2, 4'd2, 4'd14, 1'b0, 9'd178, 1'b0}) begin
            bad++;
            $display("FAIL row1_col0: got %h expected %h", bnd[22:0], {4'd2, 4'd2, 4'd14, 1'b0, 9'd178, 1'b0});
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < N; i++) frame_px[i] = 8'((i * 37 + 11) % 256);
        build_exp();
        run_frame(6, 10, 3);
        total++;
        if (cap_q.size() != N || fd_cnt != 1) begin
            bad++;
            $display("FAIL bp_count: got %0d bundles %0d done expected %0d bundles 1 done", cap_q.size(), fd_cnt, N);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL bp_model[%0d]: got %h expected %h", i, (i < cap_q.size()) ? cap_q[i] : 'x, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        bus.frame_start = 1'b1;
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.pixel_valid = 1'b1;
            bus.pixel_in = 8'(200 - 9*i);
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        #2;
        total++;
        if ({bus.out_valid, bus.busy, bus.frame_done, bus.pixel_ready, bus.fsm_state, pack_out()} !== 37'h0) begin
            bad++;
            $display("FAIL midreset_outputs: got %h expected 0", {bus.out_valid, bus.busy, bus.frame_done, bus.pixel_ready, bus.fsm_state, pack_out()});
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.busy, bus.pixel_ready, bus.out_valid} !== 3'b000) begin
            bad++;
            $display("FAIL midreset_stays_idle: got %b expected 000", {bus.busy, bus.pixel_ready, bus.out_valid});
        end
        bus.pixel_valid = 1'b0;
        for (int i = 0; i < N; i++) frame_px[i] = 8'((i * 53 + 7) % 256);
        build_exp();
        run_frame(-1, 0, -1);
        total++;
        if (cap_q.size() != N || fd_cnt != 1) begin
            bad++;
            $display("FAIL midreset_count: got %0d bundles %0d done expected %0d bundles 1 done", cap_q.size(), fd_cnt, N);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL midreset_model[%0d]: got %h expected %h", i, (i < cap_q.size()) ? cap_q[i] : 'x, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_positive_context();
        test_negative_context();
        test_flat();
        test_row0_edges();
        test_backpressure();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
